mem_stage: RTL and testbench

Memory-access stage of the five-stage pipeline; consumes the execute stage's outputs (ALU result, store data, memory control, size/extension) and drives the data-memory request/acknowledge port. Contains the MEM pipeline register, a two-state access FSM that holds the pipeline while memory is slow, big-endian byte-lane steering for stores and lane extraction/extension for loads. Results go to the write-back stage.

---
 rtl/mem_pkg.sv | 44 ++++
 rtl/mem_lane_align.sv | 49 ++++
 rtl/mem_stage.sv | 165 ++++++++++++++++
 tb/tb_mem_stage.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the memory-access stage: access sizes, FSM states,
// byte-enable patterns and the MEM pipeline register layout.
package mem_pkg;

    localparam logic [1:0] DSIZE_WORD = 2'b00;
    localparam logic [1:0] DSIZE_HALF = 2'b01;
    localparam logic [1:0] DSIZE_BYTE = 2'b10;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_BYTE_0  = 4'b1000;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } mem_state_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] aluout;
        logic [31:0] busb;
        logic [31:0] delayslot2;
        logic        memwr;
        logic        memtoreg;
        logic        regwrite;
        logic        jump;
        logic        jal;
        logic        loadext;
        logic [1:0]  dsize;
        logic [1:0]  fpoint;
        logic [4:0]  rw;
    } mem_reg_t;

    // Encoding 2'b11 behaves as a word access.
    function automatic logic addr_misaligned(input logic [1:0] dsize, input logic [1:0] a);
        case (dsize)
            DSIZE_HALF: addr_misaligned = a[0];
            DSIZE_BYTE: addr_misaligned = 1'b0;
            default:    addr_misaligned = (a != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian byte-lane steering: store byte enables and replicated write data,
// plus load lane extraction with sign/zero extension.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  dsize,
    input  logic        loadext,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] load_raw,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane 0 (address offset 0) is the most significant byte.
    always_comb begin
        case (addr_lo)
            2'b00:   byte_sel = load_raw[31:24];
            2'b01:   byte_sel = load_raw[23:16];
            2'b10:   byte_sel = load_raw[15:8];
            default: byte_sel = load_raw[7:0];
        endcase
        half_sel = addr_lo[1] ? load_raw[15:0] : load_raw[31:16];
    end

    always_comb begin
        be        = BE_WORD;
        wdata     = store_data;
        load_data = load_raw;
        case (dsize)
            DSIZE_HALF: begin
                be        = addr_lo[1] ? BE_HALF_LO : BE_HALF_HI;
                wdata     = {2{store_data[15:0]}};
                load_data = {{16{loadext & half_sel[15]}}, half_sel};
            end
            DSIZE_BYTE: begin
                be        = BE_BYTE_0 >> addr_lo;
                wdata     = {4{store_data[7:0]}};
                load_data = {{24{loadext & byte_sel[7]}}, byte_sel};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: MEM register, access FSM and data-memory port.
// Optional MEM_ALIGN_CHECK_EN suppresses misaligned half/word accesses and flags them.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no access outstanding; MEM holds a non-memory op or bubble
// ST_ACCESS | dmem_req asserted for the op in MEM; pipeline frozen until ack
module mem_stage
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic [31:0] dInst,
    input  logic [31:0] dALUout,
    input  logic [31:0] dBusB,
    input  logic [31:0] dDelayslot2,
    input  logic        dMemWr,
    input  logic        dMemToReg,
    input  logic        dRegWrite,
    input  logic        dJump,
    input  logic        dJal,
    input  logic        dLoadext,
    input  logic [1:0]  dDsize,
    input  logic [1:0]  dFPoint,
    input  logic [4:0]  dRw,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        mem_busy,
    output logic [31:0] Instruction,
    output logic [31:0] ALUout,
    output logic [31:0] MemData,
    output logic [31:0] Delayslot2,
    output logic        RegWr,
    output logic        MemToReg,
    output logic        Jal,
    output logic        Jump,
    output logic [1:0]  FPoint,
    output logic [4:0]  Rw,
    output logic        misalign
);

    mem_reg_t   mem_in;
    mem_reg_t   mem_q;
    mem_reg_t   mem_d;
    mem_state_e state_q;
    mem_state_e state_d;

    logic        access;
    logic        busy;
    logic        d_memop;
    logic        d_misalign;
    logic        q_misalign;
    logic        start_access;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] lane_load;

    always_comb begin
        mem_in            = '0;
        mem_in.inst       = dInst;
        mem_in.aluout     = dALUout;
        mem_in.busb       = dBusB;
        mem_in.delayslot2 = dDelayslot2;
        mem_in.memwr      = dMemWr;
        mem_in.memtoreg   = dMemToReg;
        mem_in.regwrite   = dRegWrite;
        mem_in.jump       = dJump;
        mem_in.jal        = dJal;
        mem_in.loadext    = dLoadext;
        mem_in.dsize      = dDsize;
        mem_in.fpoint     = dFPoint;
        mem_in.rw         = dRw;
    end

`ifdef MEM_ALIGN_CHECK_EN
    assign d_misalign = addr_misaligned(dDsize, dALUout[1:0]);
    assign q_misalign = (mem_q.memwr | mem_q.memtoreg) &
                        addr_misaligned(mem_q.dsize, mem_q.aluout[1:0]);
`else
    assign d_misalign = 1'b0;
    assign q_misalign = 1'b0;
`endif

    assign d_memop      = dMemWr | dMemToReg;
    assign start_access = ~stall & d_memop & ~d_misalign;

    // Busy beats stall: the register only advances once the access completes.
    always_comb begin
        mem_d = mem_q;
        if (!busy) begin
            mem_d = stall ? '0 : mem_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_access) state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (dmem_ack) state_d = start_access ? ST_ACCESS : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        access = (state_q == ST_ACCESS);
        busy   = access & ~dmem_ack;
    end

    mem_lane_align u_lane_align (
        .dsize      (mem_q.dsize),
        .loadext    (mem_q.loadext),
        .addr_lo    (mem_q.aluout[1:0]),
        .store_data (mem_q.busb),
        .load_raw   (dmem_rdata),
        .be         (lane_be),
        .wdata      (lane_wdata),
        .load_data  (lane_load)
    );

    assign dmem_req    = access;
    assign dmem_we     = mem_q.memwr;
    assign dmem_addr   = {mem_q.aluout[31:2], 2'b00};
    assign dmem_be     = access ? lane_be : 4'b0000;
    assign dmem_wdata  = access ? lane_wdata : 32'h0;
    assign mem_busy    = busy;

    assign Instruction = mem_q.inst;
    assign ALUout      = mem_q.aluout;
    assign MemData     = (access & dmem_ack) ? lane_load : 32'h0;
    assign Delayslot2  = mem_q.delayslot2;
    assign RegWr       = mem_q.regwrite & ~busy & ~q_misalign;
    assign MemToReg    = mem_q.memtoreg;
    assign Jal         = mem_q.jal;
    assign Jump        = mem_q.jump;
    assign FPoint      = mem_q.fpoint;
    assign Rw          = mem_q.rw;
    assign misalign    = q_misalign;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed instruction sequence with cycle-tagged expectations.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic [31:0] dInst, dALUout, dBusB, dDelayslot2;
    logic        dMemWr, dMemToReg, dRegWrite, dJump, dJal, dLoadext;
    logic [1:0]  dDsize, dFPoint;
    logic [4:0]  dRw;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata, dmem_rdata;
    logic        dmem_ack, mem_busy;
    logic [31:0] Instruction, ALUout, MemData, Delayslot2;
    logic        RegWr, MemToReg, Jal, Jump;
    logic [1:0]  FPoint;
    logic [4:0]  Rw;
    logic        misalign;

    mem_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .dInst(dInst), .dALUout(dALUout), .dBusB(dBusB), .dDelayslot2(dDelayslot2),
        .dMemWr(dMemWr), .dMemToReg(dMemToReg), .dRegWrite(dRegWrite), .dJump(dJump),
        .dJal(dJal), .dLoadext(dLoadext), .dDsize(dDsize), .dFPoint(dFPoint), .dRw(dRw),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .mem_busy(mem_busy), .Instruction(Instruction), .ALUout(ALUout), .MemData(MemData),
        .Delayslot2(Delayslot2), .RegWr(RegWr), .MemToReg(MemToReg), .Jal(Jal), .Jump(Jump),
        .FPoint(FPoint), .Rw(Rw), .misalign(misalign)
    );

    always #5 clk = ~clk;

    typedef enum int {
        F_REQ, F_WE, F_ADDR, F_BE, F_WDATA, F_BUSY, F_MEMDATA,
        F_REGWR, F_INST, F_ALU, F_RW, F_MIS, F_JAL, F_DS2
    } field_e;

    typedef struct {
        int          cyc;
        field_e      f;
        logic [31:0] v;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    exp_t keep_q[$];
    int   cyc     = 0;
    int   n_pass  = 0;
    int   n_total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] obs(input field_e f);
        case (f)
            F_REQ:     return {31'b0, dmem_req};
            F_WE:      return {31'b0, dmem_we};
            F_ADDR:    return dmem_addr;
            F_BE:      return {28'b0, dmem_be};
            F_WDATA:   return dmem_wdata;
            F_BUSY:    return {31'b0, mem_busy};
            F_MEMDATA: return MemData;
            F_REGWR:   return {31'b0, RegWr};
            F_INST:    return Instruction;
            F_ALU:     return ALUout;
            F_RW:      return {27'b0, Rw};
            F_MIS:     return {31'b0, misalign};
            F_JAL:     return {31'b0, Jal};
            default:   return Delayslot2;
        endcase
    endfunction

    task automatic expect_at(input int c, input field_e f, input logic [31:0] v, input string name);
        exp_t e;
        e.cyc  = c;
        e.f    = f;
        e.v    = v;
        e.name = name;
        exp_q.push_back(e);
    endtask

    // Compare every expectation that falls due in the current cycle.
    always @(negedge clk) begin
        keep_q.delete();
        foreach (exp_q[i]) begin
            if (exp_q[i].cyc == cyc) begin
                n_total++;
                if (obs(exp_q[i].f) === exp_q[i].v) n_pass++;
                else $display("FAIL %s (cycle %0d): got 0x%08h, want 0x%08h",
                              exp_q[i].name, cyc, obs(exp_q[i].f), exp_q[i].v);
            end else if (exp_q[i].cyc < cyc) begin
                n_total++;
                $display("FAIL %s: due cycle %0d never sampled, want 0x%08h",
                         exp_q[i].name, exp_q[i].cyc, exp_q[i].v);
            end else begin
                keep_q.push_back(exp_q[i]);
            end
        end
        exp_q = keep_q;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] inst, input logic [31:0] alu, input logic [31:0] busb,
                         input logic wr, input logic rd, input logic rwe,
                         input logic [1:0] sz, input logic ext, input logic [4:0] ridx);
        dInst = inst; dALUout = alu; dBusB = busb;
        dMemWr = wr; dMemToReg = rd; dRegWrite = rwe;
        dDsize = sz; dLoadext = ext; dRw = ridx;
        dJump = 1'b0; dJal = 1'b0; dDelayslot2 = 32'h0; dFPoint = 2'b00;
    endtask

    task automatic nop();
        drive(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        rst_n = 1'b0; stall = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
        nop();
        tick();
        tick();
        c = cyc;
        rst_n = 1'b1;
        expect_at(c, F_REQ,  0, "rst_req");
        expect_at(c, F_INST, 0, "rst_inst");
        expect_at(c, F_BUSY, 0, "rst_busy");
        expect_at(c, F_REGWR,0, "rst_regwr");
        expect_at(c, F_BE,   0, "rst_be");
        expect_at(c, F_ADDR, 0, "rst_addr");

        // word store, zero-wait memory
        drive(32'hAC00_0001, 32'h100, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0);
        tick(); c = cyc;
        dmem_ack = 1'b1;
        expect_at(c, F_REQ,   1,            "sw_req");
        expect_at(c, F_WE,    1,            "sw_we");
        expect_at(c, F_ADDR,  32'h100,      "sw_addr");
        expect_at(c, F_BE,    4'b1111,      "sw_be");
        expect_at(c, F_WDATA, 32'hDEADBEEF, "sw_wdata");
        expect_at(c, F_BUSY,  0,            "sw_busy");
        drive(32'h0111_1111, 32'h55, 32'h0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 5'd5);
        dJal = 1'b1; dDelayslot2 = 32'h108;
        tick(); c = cyc;
        dmem_ack = 1'b0;
        expect_at(c, F_REQ,   0,            "alu_req");
        expect_at(c, F_REGWR, 1,            "alu_regwr");
        expect_at(c, F_ALU,   32'h55,       "alu_aluout");
        expect_at(c, F_RW,    5,            "alu_rw");
        expect_at(c, F_INST,  32'h0111_1111,"alu_inst");
        expect_at(c, F_JAL,   1,            "alu_jal");
        expect_at(c, F_DS2,   32'h108,      "alu_ds2");

        // byte load sign-extend, ack after three wait cycles
        drive(32'h8000_0002, 32'h103, 32'h0, 1'b0, 1'b1, 1'b1, 2'b10, 1'b1, 5'd7);
        tick(); c = cyc;
        for (int k = 0; k < 3; k++) begin
            expect_at(c + k, F_REQ,   1, "lb_req_wait");
            expect_at(c + k, F_BUSY,  1, "lb_busy_wait");
            expect_at(c + k, F_REGWR, 0, "lb_regwr_wait");
        end
        expect_at(c,     F_WE,      0,            "lb_we");
        expect_at(c,     F_ADDR,    32'h100,      "lb_addr");
        expect_at(c,     F_MEMDATA, 0,            "lb_memdata_wait");
        expect_at(c + 3, F_REQ,     1,            "lb_req_ack");
        expect_at(c + 3, F_BUSY,    0,            "lb_busy_ack");
        expect_at(c + 3, F_MEMDATA, 32'hFFFFFFF4, "lb_memdata");
        expect_at(c + 3, F_REGWR,   1,            "lb_regwr_ack");
        expect_at(c + 3, F_RW,      7,            "lb_rw");
        drive(32'hA000_0003, 32'h102, 32'h0000ABCD, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 5'd0);
        tick(); tick(); tick();
        dmem_ack = 1'b1; dmem_rdata = 32'h1122_33F4;

        // back-to-back halfword store
        tick(); c = cyc;
        dmem_rdata = 32'h0;
        expect_at(c, F_REQ,   1,            "sh_req");
        expect_at(c, F_WE,    1,            "sh_we");
        expect_at(c, F_ADDR,  32'h100,      "sh_addr");
        expect_at(c, F_BE,    4'b0011,      "sh_be");
        expect_at(c, F_WDATA, 32'hABCDABCD, "sh_wdata");
        expect_at(c, F_INST,  32'hA000_0003,"sh_inst");
        stall = 1'b1;
        drive(32'h2222_2222, 32'h77, 32'h0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 5'd9);
        tick(); c = cyc;
        dmem_ack = 1'b0;
        stall = 1'b0;
        expect_at(c, F_INST,  0, "bub_inst");
        expect_at(c, F_REGWR, 0, "bub_regwr");
        expect_at(c, F_REQ,   0, "bub_req");
        expect_at(c, F_ALU,   0, "bub_alu");
        expect_at(c, F_RW,    0, "bub_rw");
        expect_at(c, F_WE,    0, "bub_we");
        expect_at(c, F_WDATA, 0, "bub_wdata");
        tick(); c = cyc;
        expect_at(c, F_INST,  32'h2222_2222, "post_bub_inst");
        expect_at(c, F_REGWR, 1,             "post_bub_regwr");
        expect_at(c, F_RW,    9,             "post_bub_rw");

        // halfword load zero-extend with stall during access
        drive(32'h8400_0004, 32'h200, 32'h0, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 5'd3);
        tick(); c = cyc;
        expect_at(c, F_REQ,  1,       "lh_req");
        expect_at(c, F_ADDR, 32'h200, "lh_addr");
        expect_at(c, F_BUSY, 1,       "lh_busy");
        stall = 1'b1;
        drive(32'h3333_3333, 32'h99, 32'h0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 5'd10);
        tick(); c = cyc;
        stall = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'h89AB_1234;
        expect_at(c, F_INST,    32'h8400_0004, "lh_hold_inst");
        expect_at(c, F_RW,      3,             "lh_hold_rw");
        expect_at(c, F_REQ,     1,             "lh_hold_req");
        expect_at(c, F_MEMDATA, 32'h0000_89AB, "lh_memdata");
        expect_at(c, F_REGWR,   1,             "lh_regwr");
        tick(); c = cyc;
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        expect_at(c, F_INST, 32'h3333_3333, "after_lh_inst");
        expect_at(c, F_REQ,  0,             "after_lh_req");
        expect_at(c, F_RW,   10,            "after_lh_rw");

        // byte store interrupted by reset; late ack ignored
        drive(32'hA400_0005, 32'h301, 32'h0000_00A5, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 5'd0);
        tick(); c = cyc;
        expect_at(c, F_REQ,   1,            "sb_req");
        expect_at(c, F_ADDR,  32'h300,      "sb_addr");
        expect_at(c, F_BE,    4'b0100,      "sb_be");
        expect_at(c, F_WDATA, 32'hA5A5A5A5, "sb_wdata");
        expect_at(c, F_BUSY,  1,            "sb_busy");
        rst_n = 1'b0;
        nop();
        tick(); c = cyc;
        rst_n = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        expect_at(c, F_REQ,     0, "rstacc_req");
        expect_at(c, F_BUSY,    0, "rstacc_busy");
        expect_at(c, F_INST,    0, "rstacc_inst");
        expect_at(c, F_ALU,     0, "rstacc_alu");
        expect_at(c, F_WE,      0, "rstacc_we");
        expect_at(c, F_MEMDATA, 0, "rstacc_memdata");
        expect_at(c, F_BE,      0, "rstacc_be");
        tick(); c = cyc;
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        expect_at(c, F_REQ, 0, "late_ack_req");

        // word load at 0x102
        drive(32'h8C00_0006, 32'h102, 32'h0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 5'd4);
        tick(); c = cyc;
        dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
        nop();
`ifdef MEM_ALIGN_CHECK_EN
        expect_at(c, F_REQ,     0, "lw_mis_req");
        expect_at(c, F_MIS,     1, "lw_mis_flag");
        expect_at(c, F_REGWR,   0, "lw_mis_regwr");
        expect_at(c, F_BUSY,    0, "lw_mis_busy");
        expect_at(c, F_MEMDATA, 0, "lw_mis_memdata");
`else
        expect_at(c, F_REQ,     1,             "lw_req");
        expect_at(c, F_ADDR,    32'h100,       "lw_addr");
        expect_at(c, F_MIS,     0,             "lw_mis_flag");
        expect_at(c, F_MEMDATA, 32'hCAFE_F00D, "lw_memdata");
        expect_at(c, F_REGWR,   1,             "lw_regwr");
`endif
        tick(); c = cyc;
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        expect_at(c, F_MIS, 0, "lw_after_mis");
        expect_at(c, F_REQ, 0, "lw_after_req");

        tick();
        tick();
        @(negedge clk);
        #1;
        foreach (exp_q[i]) begin
            n_total++;
            $display("FAIL %s: expectation for cycle %0d left unchecked, want 0x%08h",
                     exp_q[i].name, exp_q[i].cyc, exp_q[i].v);
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
